// File: rtl/yf_run_ctrl.sv
// Run controller for the yfcpu core: streams a program into IMEM, then runs or single-steps
// the core. Commands are taken on cmd_valid & cmd_ready; program words on ld_valid & ld_ready.
module yf_run_ctrl #(
    parameter int IM_W  = 8,
    parameter int IW    = 16,
    parameter int CNT_W = 16,
    parameter int WDOG  = 1000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    input  logic             ld_valid,
    input  logic [IW-1:0]    ld_data,
    input  logic             ld_last,
    output logic             ld_ready,
    output logic             imem_we,
    output logic [IM_W-1:0]  imem_addr,
    output logic [IW-1:0]    imem_wdata,
    output logic             cpu_rst,
    output logic             cpu_en,
    input  logic [1:0]       cpu_state,
    input  logic [3:0]       cpu_opcode,
    output logic             busy,
    output logic             halted,
    output logic             timeout,
    output logic             load_ovf,
    output logic [CNT_W-1:0] instr_count,
    output logic [2:0]       dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_RUN    = 3'd2,
        S_STEP   = 3'd3,
        S_HALTED = 3'd4
    } state_t;

    localparam logic [1:0] CMD_LOAD = 2'b00;
    localparam logic [1:0] CMD_RUN  = 2'b01;
    localparam logic [1:0] CMD_STEP = 2'b10;
    localparam logic [1:0] CMD_STOP = 2'b11;

    localparam int CYC_W = (WDOG > 1) ? $clog2(WDOG + 1) : 1;
    localparam logic [CYC_W-1:0] WDOG_LAST = (WDOG > 0) ? CYC_W'(WDOG - 1) : '0;
    localparam bit WDOG_ON = (WDOG != 0);

    state_t            state_q, state_d;
    logic              cpu_rst_q, cpu_rst_d;
    logic              cpu_en_q, cpu_en_d;
    logic              imem_we_q, imem_we_d;
    logic [IM_W-1:0]   imem_addr_q, imem_addr_d;
    logic [IW-1:0]     imem_wdata_q, imem_wdata_d;
    logic [IM_W-1:0]   addr_q, addr_d;
    logic              wrap_q, wrap_d;
    logic              halted_q, halted_d;
    logic              timeout_q, timeout_d;
    logic              load_ovf_q, load_ovf_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [CYC_W-1:0]  cyc_q, cyc_d;
    logic              busy_q, busy_d;
    logic              ld_ready_q, ld_ready_d;

    logic cmd_fire;
    logic retire;
    logic halt_det;
    logic wd_hit;

    // Only STOP can be taken while the core is running; everything else waits for IDLE/HALTED.
    always_comb begin
        cmd_ready = 1'b0;
        case (state_q)
            S_IDLE, S_HALTED: cmd_ready = 1'b1;
            S_RUN, S_STEP:    cmd_ready = (cmd == CMD_STOP);
            default:          cmd_ready = 1'b0;
        endcase
    end

    assign cmd_fire = cmd_valid & cmd_ready;
    assign retire   = cpu_en_q & (cpu_state == 2'b11);
    assign halt_det = cpu_en_q & (cpu_state == 2'b10) & (cpu_opcode == 4'b0000);
    assign wd_hit   = WDOG_ON & cpu_en_q & (cyc_q == WDOG_LAST);

    always_comb begin
        state_d      = state_q;
        cpu_rst_d    = cpu_rst_q;
        cpu_en_d     = 1'b0;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        addr_d       = addr_q;
        wrap_d       = wrap_q;
        halted_d     = halted_q;
        timeout_d    = timeout_q;
        load_ovf_d   = load_ovf_q;
        cnt_d        = cnt_q;
        cyc_d        = cyc_q;

        if (cpu_en_q) begin
            cyc_d = cyc_q + 1'b1;
        end
        if (retire) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            S_IDLE, S_HALTED: begin
                cpu_rst_d = 1'b0;
                if (cmd_fire) begin
                    case (cmd)
                        CMD_LOAD: begin
                            state_d    = S_LOAD;
                            cpu_rst_d  = 1'b1;
                            addr_d     = '0;
                            wrap_d     = 1'b0;
                            cnt_d      = '0;
                            load_ovf_d = 1'b0;
                            halted_d   = 1'b0;
                            timeout_d  = 1'b0;
                        end
                        CMD_RUN, CMD_STEP: begin
                            cyc_d     = '0;
                            timeout_d = 1'b0;
                            // A halted core stays put: the command is consumed without enabling it.
                            if (state_q == S_IDLE) begin
                                state_d  = (cmd == CMD_RUN) ? S_RUN : S_STEP;
                                cpu_en_d = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            S_LOAD: begin
                cpu_rst_d = 1'b1;
                if (ld_valid && ld_ready_q) begin
                    imem_we_d    = 1'b1;
                    imem_addr_d  = addr_q;
                    imem_wdata_d = ld_data;
                    addr_d       = addr_q + 1'b1;
                    if (&addr_q) begin
                        wrap_d = 1'b1;
                    end
                    if (wrap_q) begin
                        load_ovf_d = 1'b1;
                    end
                    if (ld_last) begin
                        state_d   = S_IDLE;
                        cpu_rst_d = 1'b0;
                    end
                end
            end
            S_RUN, S_STEP: begin
                cpu_en_d = 1'b1;
                // Exit priority: HALT, then watchdog, then step-complete / STOP.
                if (halt_det) begin
                    state_d  = S_HALTED;
                    halted_d = 1'b1;
                    cpu_en_d = 1'b0;
                end else if (wd_hit) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                    cpu_en_d  = 1'b0;
                end else if (((state_q == S_STEP) && retire) || cmd_fire) begin
                    state_d  = S_IDLE;
                    cpu_en_d = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d     = (state_d == S_LOAD) || (state_d == S_RUN) || (state_d == S_STEP);
        ld_ready_d = (state_d == S_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cpu_rst_q    <= 1'b1;
            cpu_en_q     <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            addr_q       <= '0;
            wrap_q       <= 1'b0;
            halted_q     <= 1'b0;
            timeout_q    <= 1'b0;
            load_ovf_q   <= 1'b0;
            cnt_q        <= '0;
            cyc_q        <= '0;
            busy_q       <= 1'b0;
            ld_ready_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cpu_rst_q    <= cpu_rst_d;
            cpu_en_q     <= cpu_en_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            addr_q       <= addr_d;
            wrap_q       <= wrap_d;
            halted_q     <= halted_d;
            timeout_q    <= timeout_d;
            load_ovf_q   <= load_ovf_d;
            cnt_q        <= cnt_d;
            cyc_q        <= cyc_d;
            busy_q       <= busy_d;
            ld_ready_q   <= ld_ready_d;
        end
    end

    assign ld_ready    = ld_ready_q;
    assign imem_we     = imem_we_q;
    assign imem_addr   = imem_addr_q;
    assign imem_wdata  = imem_wdata_q;
    assign cpu_rst     = cpu_rst_q;
    assign cpu_en      = cpu_en_q;
    assign busy        = busy_q;
    assign halted      = halted_q;
    assign timeout     = timeout_q;
    assign load_ovf    = load_ovf_q;
    assign instr_count = cnt_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_yf_run_ctrl.sv
// Bench for yf_run_ctrl: a tiny 4-phase core stub plus an instruction-level reference model.
module tb_yf_run_ctrl;
    localparam int IM_W = 8, IW = 16, CNT_W = 16, WDOG = 40, DEPTH = 256;
    localparam logic [1:0] CMD_LOAD = 2'b00, CMD_RUN = 2'b01, CMD_STEP = 2'b10, CMD_STOP = 2'b11;

    logic clk, rst, cmd_valid, cmd_ready, ld_valid, ld_last, ld_ready, imem_we;
    logic [1:0] cmd, cpu_state;
    logic [IW-1:0] ld_data, imem_wdata;
    logic [IM_W-1:0] imem_addr;
    logic cpu_rst, cpu_en, busy, halted, timeout, load_ovf;
    logic [3:0] cpu_opcode;
    logic [CNT_W-1:0] instr_count;
    logic [2:0] dbg_state;

    yf_run_ctrl #(.IM_W(IM_W), .IW(IW), .CNT_W(CNT_W), .WDOG(WDOG)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd(cmd), .cmd_ready(cmd_ready),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .cpu_rst(cpu_rst), .cpu_en(cpu_en), .cpu_state(cpu_state), .cpu_opcode(cpu_opcode),
        .busy(busy), .halted(halted), .timeout(timeout), .load_ovf(load_ovf),
        .instr_count(instr_count), .dbg_state(dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // core stub: IMEM image written by the DUT, fetch->decode->execute->store per enabled cycle
    logic [IW-1:0] imem [DEPTH];
    logic [1:0] core_st;
    logic [IM_W-1:0] core_pc;
    always @(posedge clk) begin
        if (imem_we) imem[imem_addr] <= imem_wdata;
        if (cpu_rst) begin
            core_st <= 2'd0;
            core_pc <= '0;
        end else if (cpu_en) begin
            core_st <= core_st + 2'd1;
            if (core_st == 2'd3) core_pc <= core_pc + 1'b1;
        end
    end
    assign cpu_state  = core_st;
    assign cpu_opcode = imem[core_pc][15:12];

    // scoreboard and reference model state
    int n_checks = 0;
    int n_fail = 0;
    logic [IM_W+IW-1:0] exp_q[$];
    logic [IW-1:0] exp_mem [DEPTH];
    logic [IW-1:0] prog[$];
    int m_pc, m_phase, m_cnt;
    bit m_halted, m_ovf;
    logic [47:0] rst_vec;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        m_pc = 0; m_phase = 0; m_cnt = 0; m_halted = 0; m_ovf = 0;
    endtask

    // Instruction-level prediction: a non-HALT instruction costs 4 enabled cycles from fetch,
    // a HALT is detected after 3; the command ends at the first HALT, the watchdog, STOP or step end.
    task automatic predict(input bit step_mode, input int stop_at, output int en, output bit hlt,
                           output bit to, output int ret);
        int budget, c;
        bit done;
        budget = WDOG;
        if (stop_at > 0 && stop_at < budget) budget = stop_at;
        en = 0; hlt = 0; to = 0; ret = 0; done = 0;
        while (!done) begin
            if (exp_mem[m_pc][15:12] == 4'h0 && m_phase <= 2) begin
                c = 3 - m_phase;
                if (en + c <= budget) begin en += c; hlt = 1; m_phase = 3; end
                else begin m_phase += budget - en; en = budget; end
                done = 1;
            end else begin
                c = 4 - m_phase;
                if (en + c <= budget) begin
                    en += c; ret++; m_pc = (m_pc + 1) % DEPTH; m_phase = 0;
                    if (step_mode || en == budget) done = 1;
                end else begin
                    m_phase += budget - en; en = budget; done = 1;
                end
            end
        end
        if (!hlt && en == WDOG) to = 1;
        m_cnt = (m_cnt + ret) % (1 << CNT_W);
        if (hlt) m_halted = 1;
    endtask

    // driver: one command, returns whether it was accepted
    task automatic issue_cmd(input logic [1:0] c, output bit acc);
        cmd_valid = 1'b1; cmd = c;
        #1 acc = cmd_ready;
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic gen_prog(input int n, input bit allow_halt);
        logic [3:0] op;
        prog.delete();
        for (int i = 0; i < n; i++) begin
            op = 4'($urandom_range(1, 15));
            if (allow_halt && $urandom_range(0, 5) == 0) op = 4'h0;
            prog.push_back({op, 12'($urandom)});
        end
    endtask

    // driver: load the words in prog, checking every IMEM write against the expected queue
    task automatic do_load(input bit gaps, input bit poke_cmd);
        bit acc;
        logic [IM_W-1:0] a;
        logic [IM_W+IW-1:0] e;
        int n;
        n = prog.size();
        issue_cmd(CMD_LOAD, acc);
        n_checks++; if (acc !== 1'b1) begin n_fail++; $display("FAIL load_accept: got %b want 1", acc); end
        model_reset();
        n_checks++; if ({ld_ready, cpu_rst, busy} !== 3'b111) begin n_fail++;
            $display("FAIL load_enter: ld_ready/cpu_rst/busy got %b want 111", {ld_ready, cpu_rst, busy}); end
        for (int i = 0; i < n; i++) begin
            if (gaps) begin
                repeat ($urandom_range(0, 2)) begin
                    if (poke_cmd) begin cmd_valid = 1'b1; cmd = CMD_RUN; end
                    #1;
                    n_checks++; if (cmd_ready !== 1'b0) begin n_fail++; $display("FAIL load_cmd_ready: got %b want 0", cmd_ready); end
                    tick();
                    cmd_valid = 1'b0;
                    n_checks++; if ({imem_we, cpu_en} !== 2'b00) begin n_fail++;
                        $display("FAIL load_gap: imem_we/cpu_en got %b want 00", {imem_we, cpu_en}); end
                end
            end
            a = IM_W'(i % DEPTH);
            exp_q.push_back({a, prog[i]});
            exp_mem[i % DEPTH] = prog[i];
            if (i >= DEPTH) m_ovf = 1;
            ld_valid = 1'b1; ld_data = prog[i]; ld_last = (i == n - 1);
            tick();
            ld_valid = 1'b0; ld_last = 1'b0;
            e = exp_q.pop_front();
            n_checks++; if (imem_we !== 1'b1 || {imem_addr, imem_wdata} !== e) begin n_fail++;
                $display("FAIL load_write[%0d]: got we=%b addr=%0d data=%h want addr=%0d data=%h",
                         i, imem_we, imem_addr, imem_wdata, e[IM_W+IW-1:IW], e[IW-1:0]); end
            n_checks++; if ({cpu_rst, load_ovf} !== {(i != n - 1), m_ovf}) begin n_fail++;
                $display("FAIL load_flags[%0d]: cpu_rst/load_ovf got %b%b want %b%b", i, cpu_rst, load_ovf, (i != n - 1), m_ovf); end
        end
        n_checks++; if ({ld_ready, busy, cpu_en, instr_count} !== 19'd0) begin n_fail++;
            $display("FAIL load_exit: ld_ready=%b busy=%b cpu_en=%b count=%0d want all 0", ld_ready, busy, cpu_en, instr_count); end
    endtask

    // driver: RUN or STEP from IDLE, optional STOP after stop_at enabled cycles
    task automatic do_exec(input bit step_mode, input int stop_at, output int en_obs);
        int en_exp, ret_exp, guard;
        bit h_exp, t_exp, acc;
        predict(step_mode, stop_at, en_exp, h_exp, t_exp, ret_exp);
        issue_cmd(step_mode ? CMD_STEP : CMD_RUN, acc);
        n_checks++; if (acc !== 1'b1 || timeout !== 1'b0) begin n_fail++;
            $display("FAIL exec_accept: acc=%b timeout=%b want 1/0", acc, timeout); end
        en_obs = 0; guard = 0;
        while (cpu_en === 1'b1 && guard < 500) begin
            en_obs++;
            if (stop_at > 0 && en_obs == stop_at) begin cmd_valid = 1'b1; cmd = CMD_STOP; end
            tick();
            cmd_valid = 1'b0;
            guard++;
        end
        n_checks++; if (guard >= 500) begin n_fail++; $display("FAIL exec_bound: cpu_en still high after %0d cycles", guard); end
        n_checks++; if (en_obs != en_exp) begin n_fail++; $display("FAIL exec_en_cycles: got %0d want %0d", en_obs, en_exp); end
        n_checks++; if ({halted, timeout, busy, cpu_rst} !== {h_exp, t_exp, 2'b00}) begin n_fail++;
            $display("FAIL exec_flags: halted/timeout/busy/cpu_rst got %b want %b00", {halted, timeout, busy, cpu_rst}, {h_exp, t_exp}); end
        n_checks++; if (instr_count !== CNT_W'(m_cnt)) begin n_fail++; $display("FAIL exec_count: got %0d want %0d", instr_count, m_cnt); end
    endtask

    task automatic load_sample();
        prog.delete();
        prog.push_back({4'h8, 12'h011}); prog.push_back({4'h8, 12'h122}); prog.push_back({4'h8, 12'h233});
        prog.push_back({4'h1, 12'h012}); prog.push_back({4'h4, 12'h123}); prog.push_back({4'h5, 12'h201});
        prog.push_back(16'h0000);
        do_load(1'b1, 1'b1);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        rst_vec = {cpu_rst, cpu_en, imem_we, imem_addr, imem_wdata, busy, halted, timeout, load_ovf, ld_ready, instr_count};
        n_checks++; if (rst_vec !== {1'b1, 47'd0} || cmd_ready !== 1'b1) begin n_fail++;
            $display("FAIL reset_values: got %h ready=%b want %h ready=1", rst_vec, cmd_ready, {1'b1, 47'd0}); end
        rst = 1'b0;
        tick();
        n_checks++; if ({cpu_rst, cpu_en, busy} !== 3'b000) begin n_fail++;
            $display("FAIL reset_release: cpu_rst/cpu_en/busy got %b want 000", {cpu_rst, cpu_en, busy}); end
    endtask

    task automatic test_run_halt();
        int en;
        bit acc;
        load_sample();
        do_exec(1'b0, 0, en);
        n_checks++; if (en != 27 || instr_count !== 16'd6 || halted !== 1'b1) begin n_fail++;
            $display("FAIL run_halt_sample: cycles=%0d count=%0d halted=%b want 27/6/1", en, instr_count, halted); end
        issue_cmd(CMD_RUN, acc);
        repeat (3) begin
            n_checks++; if ({acc, cpu_en, halted, busy} !== 4'b1010) begin n_fail++;
                $display("FAIL run_from_halted: acc/cpu_en/halted/busy got %b want 1010", {acc, cpu_en, halted, busy}); end
            tick();
        end
    endtask

    task automatic test_step();
        int en;
        load_sample();
        for (int k = 1; k <= 3; k++) begin
            do_exec(1'b1, 0, en);
            n_checks++; if (en != 4 || instr_count !== CNT_W'(k)) begin n_fail++;
                $display("FAIL step_%0d: cycles=%0d count=%0d want 4/%0d", k, en, instr_count, k); end
        end
    endtask

    task automatic test_watchdog();
        int en;
        gen_prog(12, 1'b0);
        do_load(1'b0, 1'b0);
        do_exec(1'b0, 0, en);
        n_checks++; if (en != 40 || timeout !== 1'b1 || instr_count !== 16'd10 || busy !== 1'b0) begin n_fail++;
            $display("FAIL watchdog: cycles=%0d timeout=%b count=%0d busy=%b want 40/1/10/0", en, timeout, instr_count, busy); end
        do_exec(1'b1, 0, en);
    endtask

    task automatic test_overflow_stop();
        int en;
        gen_prog(DEPTH + 1, 1'b0);
        do_load(1'b0, 1'b0);
        n_checks++; if (load_ovf !== 1'b1 || imem_addr !== '0) begin n_fail++;
            $display("FAIL overflow: load_ovf=%b last_addr=%0d want 1/0", load_ovf, imem_addr); end
        do_exec(1'b0, 5, en);
        n_checks++; if (en != 5) begin n_fail++; $display("FAIL stop_cycles: got %0d want 5", en); end
        do_exec(1'b1, 0, en);
    endtask

    task automatic test_rst_abort();
        bit acc;
        issue_cmd(CMD_LOAD, acc);
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1; ld_data = 16'h9000 + 16'(i); ld_last = 1'b0;
            exp_mem[i] = ld_data;
            tick();
        end
        ld_valid = 1'b0; rst = 1'b1;
        tick();
        rst_vec = {cpu_rst, cpu_en, imem_we, imem_addr, imem_wdata, busy, halted, timeout, load_ovf, ld_ready, instr_count};
        n_checks++; if (rst_vec !== {1'b1, 47'd0}) begin n_fail++; $display("FAIL rst_mid_load: got %h want %h", rst_vec, {1'b1, 47'd0}); end
        rst = 1'b0; tick(); model_reset();
        load_sample();
        issue_cmd(CMD_RUN, acc);
        repeat (10) tick();
        rst = 1'b1;
        tick();
        rst_vec = {cpu_rst, cpu_en, imem_we, imem_addr, imem_wdata, busy, halted, timeout, load_ovf, ld_ready, instr_count};
        n_checks++; if (rst_vec !== {1'b1, 47'd0}) begin n_fail++; $display("FAIL rst_mid_run: got %h want %h", rst_vec, {1'b1, 47'd0}); end
        rst = 1'b0; tick(); model_reset();
    endtask

    task automatic test_random();
        int en, stop_at;
        for (int r = 0; r < 8; r++) begin
            gen_prog($urandom_range(1, 20), 1'b1);
            do_load(1'b1, 1'b0);
            stop_at = ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 45);
            do_exec(1'b0, stop_at, en);
            if (!m_halted) do_exec(1'b1, 0, en);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_time_limit: simulation did not finish");
        $fatal(1);
    end

    initial begin
        cmd_valid = 1'b0; cmd = CMD_LOAD; ld_valid = 1'b0; ld_data = '0; ld_last = 1'b0; rst = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin imem[i] = 16'hFFFF; exp_mem[i] = 16'hFFFF; end
        model_reset();
        test_reset();
        test_run_halt();
        test_step();
        test_watchdog();
        test_overflow_stop();
        test_rst_abort();
        test_run_halt();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
